// File: rtl/vrf_pkg.sv
// vrf_pkg: shared constants, FSM state and lane helpers for vec_reg_file.
// Optional same-cycle read bypass is selected with VRF_BYPASS_EN.
package vrf_pkg;

    localparam int VRF_NREGS  = 16;
    localparam int VRF_LANES  = 4;
    localparam int VRF_ELEM_W = 32;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } vrf_state_t;

    // Low bit of a lane inside a packed vector; slice is [lo +: elem_w].
    function automatic int lane_lo(input int lane, input int elem_w);
        return lane * elem_w;
    endfunction

    function automatic int lane_hi(input int lane, input int elem_w);
        return lane * elem_w + elem_w - 1;
    endfunction

endpackage

// File: rtl/vec_reg_file_read_port.sv
// vrf_read_port: one registered read port with zero-register forcing.
// With VRF_BYPASS_EN a same-cycle write to the read index is merged in.
module vrf_read_port
    import vrf_pkg::*;
#(
    parameter int NREGS  = VRF_NREGS,
    parameter int LANES  = VRF_LANES,
    parameter int ELEM_W = VRF_ELEM_W,
    localparam int AW = $clog2(NREGS),
    localparam int DW = LANES * ELEM_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic [AW-1:0]              rn,
    input  logic [NREGS-1:0][DW-1:0]   regs,
    input  logic [NREGS-1:0]           pend,
`ifdef VRF_BYPASS_EN
    input  logic                       wr,
    input  logic [AW-1:0]              wn,
    input  logic [LANES-1:0]           wmask,
    input  logic [DW-1:0]              wd,
`endif
    output logic [DW-1:0]              rd,
    output logic                       busy
);

    logic [DW-1:0] data;
    logic          bsy;

    always_comb begin
        data = regs[rn];
        bsy  = pend[rn];
`ifdef VRF_BYPASS_EN
        // pend is already the post-update view in this build
        if (wr && (wn == rn)) begin
            for (int i = 0; i < LANES; i++) begin
                if (wmask[i]) begin
                    data[lane_lo(i, ELEM_W) +: ELEM_W] =
                        wd[lane_lo(i, ELEM_W) +: ELEM_W];
                end
            end
        end
`endif
        if (clear || (rn == '0)) begin
            data = '0;
            bsy  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd   <= '0;
            busy <= 1'b0;
        end else begin
            rd   <= data;
            busy <= bsy;
        end
    end

endmodule

// File: rtl/vec_reg_file.sv
// vec_reg_file: masked multi-lane register file with pending scoreboard
// and post-reset clear sweep. VRF_BYPASS_EN enables write-to-read bypass.
module vec_reg_file
    import vrf_pkg::*;
#(
    parameter int NREGS  = VRF_NREGS,
    parameter int LANES  = VRF_LANES,
    parameter int ELEM_W = VRF_ELEM_W,
    localparam int AW = $clog2(NREGS),
    localparam int DW = LANES * ELEM_W
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ready,
    input  logic [AW-1:0]     rn1,
    input  logic [AW-1:0]     rn2,
    output logic [DW-1:0]     rd1,
    output logic [DW-1:0]     rd2,
    output logic              busy1,
    output logic              busy2,
    input  logic              we,
    input  logic [AW-1:0]     wn,
    input  logic [LANES-1:0]  wmask,
    input  logic [DW-1:0]     wd,
    input  logic              res_en,
    input  logic [AW-1:0]     res_n
);

    localparam logic [AW:0] SWEEP_END = (AW+1)'(NREGS);

    vrf_state_t               state;
    vrf_state_t               state_nx;
    logic [AW:0]              idx;
    logic [NREGS-1:0][DW-1:0] mem;
    logic [NREGS-1:0]         pending;
    logic [NREGS-1:0]         pend_nx;
    logic [NREGS-1:0]         pend_view;
    logic                     run;
    logic                     sweep;
    logic                     wr;
    logic                     rs;

    assign run   = (state == RUN);
    assign sweep = (state == CLEAR) && (idx != SWEEP_END);
    assign wr    = run && we && (wn != '0);
    assign rs    = run && res_en && (res_n != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
        end else begin
            state <= state_nx;
        end
    end

    // RUN is entered one edge after the last register has been cleared
    always_comb begin
        state_nx = state;
        unique case (state)
            CLEAR: if (idx == SWEEP_END) state_nx = RUN;
            RUN:   state_nx = RUN;
        endcase
    end

    always_comb begin
        ready = 1'b0;
        unique case (state)
            CLEAR: ready = 1'b0;
            RUN:   ready = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
        end else if (sweep) begin
            idx <= idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (sweep) begin
                mem[idx[AW-1:0]] <= '0;
            end else if (wr) begin
                for (int i = 0; i < LANES; i++) begin
                    if (wmask[i]) begin
                        mem[wn][lane_lo(i, ELEM_W) +: ELEM_W] <=
                            wd[lane_lo(i, ELEM_W) +: ELEM_W];
                    end
                end
            end
        end
    end

    // Reserve is applied after the write clear so it wins on a collision
    always_comb begin
        pend_nx = pending;
        if (wr) pend_nx[wn] = 1'b0;
        if (rs) pend_nx[res_n] = 1'b1;
        pend_nx[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pend_nx;
        end
    end

`ifdef VRF_BYPASS_EN
    assign pend_view = pend_nx;
`else
    assign pend_view = pending;
`endif

    vrf_read_port #(
        .NREGS  (NREGS),
        .LANES  (LANES),
        .ELEM_W (ELEM_W)
    ) u_port1 (
        .clk   (clk),
        .rst   (rst),
        .clear (!run),
        .rn    (rn1),
        .regs  (mem),
        .pend  (pend_view),
`ifdef VRF_BYPASS_EN
        .wr    (wr),
        .wn    (wn),
        .wmask (wmask),
        .wd    (wd),
`endif
        .rd    (rd1),
        .busy  (busy1)
    );

    vrf_read_port #(
        .NREGS  (NREGS),
        .LANES  (LANES),
        .ELEM_W (ELEM_W)
    ) u_port2 (
        .clk   (clk),
        .rst   (rst),
        .clear (!run),
        .rn    (rn2),
        .regs  (mem),
        .pend  (pend_view),
`ifdef VRF_BYPASS_EN
        .wr    (wr),
        .wn    (wn),
        .wmask (wmask),
        .wd    (wd),
`endif
        .rd    (rd2),
        .busy  (busy2)
    );

endmodule

// File: tb/tb_vec_reg_file.sv
// tb_vec_reg_file: scoreboard bench for vec_reg_file (default parameters).
// Honours VRF_BYPASS_EN for the same-cycle read expectations.
module tb_vec_reg_file;

    localparam int NREGS  = 16;
    localparam int LANES  = 4;
    localparam int ELEM_W = 32;
    localparam int AW     = 4;
    localparam int DW     = LANES * ELEM_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ready;
    logic [AW-1:0]     rn1 = '0;
    logic [AW-1:0]     rn2 = '0;
    logic [DW-1:0]     rd1;
    logic [DW-1:0]     rd2;
    logic              busy1;
    logic              busy2;
    logic              we = 1'b0;
    logic [AW-1:0]     wn = '0;
    logic [LANES-1:0]  wmask = '0;
    logic [DW-1:0]     wd = '0;
    logic              res_en = 1'b0;
    logic [AW-1:0]     res_n = '0;

    vec_reg_file dut (
        .clk    (clk),
        .rst    (rst),
        .ready  (ready),
        .rn1    (rn1),
        .rn2    (rn2),
        .rd1    (rd1),
        .rd2    (rd2),
        .busy1  (busy1),
        .busy2  (busy2),
        .we     (we),
        .wn     (wn),
        .wmask  (wmask),
        .wd     (wd),
        .res_en (res_en),
        .res_n  (res_n)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             w;
        logic [AW-1:0]    n;
        logic [LANES-1:0] mk;
        logic [31:0]      v;
        logic             r;
        logic [AW-1:0]    rs;
        logic [AW-1:0]    a1;
        logic [AW-1:0]    a2;
    } stim_t;

    typedef struct packed {
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        logic          b1;
        logic          b2;
    } exp_t;

    exp_t          q[$];
    logic [DW-1:0] mm[NREGS];
    logic          mp[NREGS];
    int            n_cmp = 0;
    int            n_bad = 0;

    function automatic logic [DW-1:0] splat(input logic [31:0] v);
        return {LANES{v}};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) begin
            mm[i] = '0;
            mp[i] = 1'b0;
        end
    endtask

    // Apply one cycle of stimulus, push the expected read result, update model
    task automatic drive(input stim_t s);
        exp_t          e;
        logic [DW-1:0] nm;
        logic          hit;
        we     = s.w;
        wn     = s.n;
        wmask  = s.mk;
        wd     = splat(s.v);
        res_en = s.r;
        res_n  = s.rs;
        rn1    = s.a1;
        rn2    = s.a2;
        nm = mm[s.n];
        for (int i = 0; i < LANES; i++)
            if (s.mk[i]) nm[i*ELEM_W +: ELEM_W] = s.v;
        hit = s.w && (s.n != '0);
        e.d1 = mm[s.a1];
        e.b1 = mp[s.a1];
        e.d2 = mm[s.a2];
        e.b2 = mp[s.a2];
`ifdef VRF_BYPASS_EN
        if (hit && s.a1 == s.n) begin
            e.d1 = nm;
            e.b1 = s.r && (s.rs == s.n);
        end
        if (hit && s.a2 == s.n) begin
            e.d2 = nm;
            e.b2 = s.r && (s.rs == s.n);
        end
`endif
        q.push_back(e);
        cyc();
        if (hit) begin
            mm[s.n] = nm;
            mp[s.n] = 1'b0;
        end
        if (s.r && s.rs != '0) mp[s.rs] = 1'b1;
        we     = 1'b0;
        res_en = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1;
        repeat (3) cyc();
        n_cmp++;
        if (ready !== 1'b0 || rd1 !== '0 || busy1 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: ready=%b rd1=%h busy1=%b want 0/0/0",
                     ready, rd1, busy1);
        end
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 16; k++) begin
            rn1 = 4'd5;
            rn2 = 4'd5;
            if (k == 10) begin
                we = 1'b1; wn = 4'd5; wmask = 4'hf; wd = splat(32'hFFFFFFFF);
                res_en = 1'b1; res_n = 4'd5;
            end
            cyc();
            we = 1'b0;
            res_en = 1'b0;
            n_cmp++;
            if (ready !== 1'b0 || rd1 !== '0 || busy1 !== 1'b0) begin
                n_bad++;
                $display("FAIL sweep_edge%0d: ready=%b rd1=%h busy1=%b want 0",
                         k, ready, rd1, busy1);
            end
        end
        cyc();
        n_cmp++;
        if (ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_rise: ready=%b want 1", ready);
        end
        drive('{1'b0, 4'd0, 4'h0, 32'h0, 1'b0, 4'd0, 4'd5, 4'd5});
        e = q.pop_front();
        n_cmp++;
        if (rd1 !== e.d1 || rd2 !== e.d2 || busy1 !== e.b1 || busy2 !== e.b2) begin
            n_bad++;
            $display("FAIL r5_after_sweep: rd1=%h busy1=%b want %h %b",
                     rd1, busy1, e.d1, e.b1);
        end
    endtask

    task automatic test_masked();
        stim_t s[3];
        exp_t  e;
        s[0] = '{1'b1, 4'd3, 4'hf, 32'h11111111, 1'b0, 4'd0, 4'd0, 4'd0};
        s[1] = '{1'b1, 4'd3, 4'h5, 32'hAAAAAAAA, 1'b0, 4'd0, 4'd0, 4'd0};
        s[2] = '{1'b0, 4'd0, 4'h0, 32'h0, 1'b0, 4'd0, 4'd3, 4'd3};
        foreach (s[i]) begin
            drive(s[i]);
            e = q.pop_front();
            n_cmp++;
            if (rd1 !== e.d1 || rd2 !== e.d2 || busy1 !== e.b1 || busy2 !== e.b2) begin
                n_bad++;
                $display("FAIL masked[%0d]: rd1=%h rd2=%h want %h %h",
                         i, rd1, rd2, e.d1, e.d2);
            end
        end
        n_cmp++;
        if (rd1 !== {32'h11111111, 32'hAAAAAAAA, 32'h11111111, 32'hAAAAAAAA}) begin
            n_bad++;
            $display("FAIL masked_const: rd1=%h", rd1);
        end
    endtask

    task automatic test_r0();
        stim_t s[2];
        exp_t  e;
        s[0] = '{1'b1, 4'd0, 4'hf, 32'hFFFFFFFF, 1'b1, 4'd0, 4'd0, 4'd0};
        s[1] = '{1'b0, 4'd0, 4'h0, 32'h0, 1'b0, 4'd0, 4'd0, 4'd0};
        foreach (s[i]) begin
            drive(s[i]);
            e = q.pop_front();
            n_cmp++;
            if (rd1 !== e.d1 || rd2 !== e.d2 || busy1 !== e.b1 || busy2 !== e.b2) begin
                n_bad++;
                $display("FAIL r0[%0d]: rd1=%h rd2=%h b=%b%b want 0",
                         i, rd1, rd2, busy1, busy2);
            end
        end
    endtask

    task automatic test_scoreboard();
        stim_t s[6];
        exp_t  e;
        s[0] = '{1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd7, 4'd0, 4'd0};
        s[1] = '{1'b0, 4'd0, 4'h0, 32'h0, 1'b0, 4'd0, 4'd7, 4'd7};
        s[2] = '{1'b1, 4'd7, 4'hf, 32'h77, 1'b1, 4'd7, 4'd7, 4'd2};
        s[3] = '{1'b0, 4'd0, 4'h0, 32'h0, 1'b0, 4'd0, 4'd7, 4'd0};
        s[4] = '{1'b1, 4'd7, 4'hf, 32'h12, 1'b0, 4'd0, 4'd0, 4'd0};
        s[5] = '{1'b0, 4'd0, 4'h0, 32'h0, 1'b0, 4'd0, 4'd7, 4'd7};
        foreach (s[i]) begin
            drive(s[i]);
            e = q.pop_front();
            n_cmp++;
            if (rd1 !== e.d1 || rd2 !== e.d2 || busy1 !== e.b1 || busy2 !== e.b2) begin
                n_bad++;
                $display("FAIL sb[%0d]: rd1=%h b1=%b b2=%b want %h %b %b",
                         i, rd1, busy1, busy2, e.d1, e.b1, e.b2);
            end
            if (i == 1 || i == 3 || i == 5) begin
                n_cmp++;
                if (busy1 !== (i != 5)) begin
                    n_bad++;
                    $display("FAIL sb_busy[%0d]: busy1=%b want %b", i, busy1, i != 5);
                end
            end
        end
    endtask

    task automatic test_bypass();
        stim_t         s[3];
        exp_t          e;
        logic [DW-1:0] want;
        s[0] = '{1'b1, 4'd9, 4'hf, 32'h5, 1'b0, 4'd0, 4'd0, 4'd0};
        s[1] = '{1'b1, 4'd9, 4'h1, 32'h9, 1'b0, 4'd0, 4'd9, 4'd9};
        s[2] = '{1'b0, 4'd0, 4'h0, 32'h0, 1'b0, 4'd0, 4'd9, 4'd9};
        foreach (s[i]) begin
            drive(s[i]);
            e = q.pop_front();
            n_cmp++;
            if (rd1 !== e.d1 || rd2 !== e.d2 || busy1 !== e.b1 || busy2 !== e.b2) begin
                n_bad++;
                $display("FAIL bypass[%0d]: rd1=%h rd2=%h want %h %h",
                         i, rd1, rd2, e.d1, e.d2);
            end
            if (i == 1) begin
`ifdef VRF_BYPASS_EN
                want = {32'h5, 32'h5, 32'h5, 32'h9};
`else
                want = {32'h5, 32'h5, 32'h5, 32'h5};
`endif
                n_cmp++;
                if (rd1 !== want || rd2 !== want) begin
                    n_bad++;
                    $display("FAIL bypass_same: rd1=%h rd2=%h want %h", rd1, rd2, want);
                end
            end
        end
        n_cmp++;
        if (rd1 !== {32'h5, 32'h5, 32'h5, 32'h9}) begin
            n_bad++;
            $display("FAIL bypass_next: rd1=%h", rd1);
        end
    endtask

    task automatic test_mid_reset();
        exp_t e;
        drive('{1'b1, 4'd4, 4'hf, 32'h44, 1'b1, 4'd4, 4'd0, 4'd0});
        void'(q.pop_front());
        rst = 1'b1;
        we = 1'b1; wn = 4'd4; wmask = 4'hf; wd = splat(32'h99);
        res_en = 1'b1; res_n = 4'd4;
        rn1 = 4'd4; rn2 = 4'd4;
        cyc();
        rst = 1'b0;
        we = 1'b0;
        res_en = 1'b0;
        model_reset();
        n_cmp++;
        if (ready !== 1'b0 || busy1 !== 1'b0 || rd1 !== '0) begin
            n_bad++;
            $display("FAIL midrst_state: ready=%b busy1=%b rd1=%h want 0",
                     ready, busy1, rd1);
        end
        for (int k = 0; k < 16; k++) begin
            cyc();
            n_cmp++;
            if (ready !== 1'b0 || busy1 !== 1'b0) begin
                n_bad++;
                $display("FAIL midrst_edge%0d: ready=%b busy1=%b want 0",
                         k, ready, busy1);
            end
        end
        cyc();
        n_cmp++;
        if (ready !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_ready: ready=%b want 1", ready);
        end
        drive('{1'b0, 4'd0, 4'h0, 32'h0, 1'b0, 4'd0, 4'd4, 4'd4});
        e = q.pop_front();
        n_cmp++;
        if (rd1 !== e.d1 || rd2 !== e.d2 || busy1 !== e.b1 || busy2 !== e.b2) begin
            n_bad++;
            $display("FAIL midrst_r4: rd1=%h busy1=%b want %h %b",
                     rd1, busy1, e.d1, e.b1);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_masked();
        test_r0();
        test_scoreboard();
        test_bypass();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
